// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Purpose  : Mode-0 SPI master, byte-wide request interface, MSB-first,
//             optional chip-select hold across bytes.
//  Option   : SPI_MASTER_LOOPBACK_EN - sample the internal mosi bit instead
//             of the miso pin.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              hold_ss,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              ssel
);

    localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
    localparam logic [7:0]         c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BITS     = c_CNT_W'(DATA_W);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LEAD  = 3'd1;
    localparam logic [2:0] c_HIGH  = 3'd2;
    localparam logic [2:0] c_LOW   = 3'd3;
    localparam logic [2:0] c_TRAIL = 3'd4;

    logic [2:0]         r_state;
    logic [7:0]         r_divCnt;
    logic [c_CNT_W-1:0] r_bitCnt;
    logic [DATA_W-1:0]  r_txShift;
    logic [DATA_W-1:0]  r_rxShift;
    logic [DATA_W-1:0]  r_rxData;
    logic               r_hold;
    logic               r_ready;
    logic               r_done;
    logic               r_sck;
    logic               r_mosi;
    logic               r_ssel;

    logic w_divDone;
    logic w_sampleBit;

    assign w_divDone = (r_divCnt == c_DIV_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_sampleBit = r_mosi;
`else
    assign w_sampleBit = miso;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_divCnt  <= 8'd0;
            r_bitCnt  <= '0;
            r_txShift <= '0;
            r_rxShift <= '0;
            r_rxData  <= '0;
            r_hold    <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_ssel    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (r_state != c_IDLE) begin
                r_divCnt <= w_divDone ? 8'd0 : r_divCnt + 8'd1;
            end

            case (r_state)
                c_IDLE: begin
                    if (start && r_ready) begin
                        r_txShift <= tx_data;
                        r_hold    <= hold_ss;
                        r_ssel    <= 1'b0;
                        r_mosi    <= tx_data[DATA_W-1];
                        r_ready   <= 1'b0;
                        r_divCnt  <= 8'd0;
                        r_state   <= c_LEAD;
                    end
                end
                c_LEAD, c_LOW: begin
                    if (w_divDone) begin
                        r_sck     <= 1'b1;
                        r_rxShift <= {r_rxShift[DATA_W-2:0], w_sampleBit};
                        r_bitCnt  <= r_bitCnt + 1'b1;
                        r_state   <= c_HIGH;
                    end
                end
                c_HIGH: begin
                    if (w_divDone) begin
                        r_sck <= 1'b0;
                        if (r_bitCnt == c_BITS) begin
                            r_rxData <= r_rxShift;
                            r_done   <= 1'b1;
                            r_bitCnt <= '0;
                            // With hold the byte ends straight into IDLE so ssel stays low.
                            if (r_hold) begin
                                r_ready <= 1'b1;
                                r_state <= c_IDLE;
                            end else begin
                                r_state <= c_TRAIL;
                            end
                        end else begin
                            r_mosi    <= r_txShift[DATA_W-2];
                            r_txShift <= {r_txShift[DATA_W-2:0], 1'b0};
                            r_state   <= c_LOW;
                        end
                    end
                end
                c_TRAIL: begin
                    if (w_divDone) begin
                        r_ssel  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign ready   = r_ready;
    assign done    = r_done;
    assign rx_data = r_rxData;
    assign sck     = r_sck;
    assign mosi    = r_mosi;
    assign ssel    = r_ssel;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master
//  Purpose  : Scoreboard bench for spi_master with a behavioural mode-0 slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    typedef struct {
        logic [7:0] data;
        int         dueCyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       hold_ss = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ready, done, sck, mosi, miso, ssel;
    logic [7:0] rx_data;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   sselHigh = 0;
    logic burstOn = 1'b0;
    exp_t       expQ[$];
    logic [7:0] slvExpQ[$];

    logic [7:0] slvMem [0:15];
    logic [3:0] slvIdx = 4'd0;
    logic [2:0] slvBit = 3'd0;
    logic [7:0] slvRx = 8'h00;

    spi_master #(.CLK_DIV(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .hold_ss(hold_ss), .ready(ready), .done(done), .rx_data(rx_data),
        .sck(sck), .mosi(mosi), .miso(miso), .ssel(ssel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign miso = 1'b0;
`else
    assign miso = slvMem[slvIdx][3'd7 - slvBit];
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural slave: shifts mosi in on sck rise, abandons a partial byte when ssel rises.
    always @(posedge sck or posedge ssel) begin : b_slave
        logic [7:0] nb;
        if (ssel) begin
            slvBit <= 3'd0;
        end else begin
            nb = {slvRx[6:0], mosi};
            slvRx <= nb;
            if (slvBit == 3'd7) begin
                slvBit <= 3'd0;
                slvIdx <= slvIdx + 4'd1;
                if (slvExpQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL slave_rx: got %0h expected no byte", nb);
                end else begin
                    check("slave_rx", {24'd0, nb}, {24'd0, slvExpQ.pop_front()});
                end
            end else begin
                slvBit <= slvBit + 3'd1;
            end
        end
    end

    always @(negedge clk) begin : b_monitor
        exp_t e;
        if (done) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got rx_data %0h expected no done", rx_data);
            end else begin
                e = expQ.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                check("done_cycle", cyc, e.dueCyc);
            end
        end
        if (burstOn && ssel) sselHigh++;
    end

    task automatic issue(input logic [7:0] tx, input logic hold, input logic [7:0] slv, output int e0);
        int n;
        n = 0;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready 0 expected 1 at cycle %0d", cyc);
        end
        slvMem[slvIdx] = slv;
        tx_data = tx;
        hold_ss = hold;
        start = 1'b1;
        e0 = cyc + 1;
`ifdef SPI_MASTER_LOOPBACK_EN
        expQ.push_back('{tx, e0 + 64});
`else
        expQ.push_back('{slv, e0 + 64});
`endif
        slvExpQ.push_back(tx);
        @(negedge clk);
        start = 1'b0;
        tx_data = ~tx;
        hold_ss = 1'b0;
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((expQ.size() != 0 || !ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy expected idle at cycle %0d", cyc);
        end
    endtask

    initial begin
        int e0;
        for (int i = 0; i < 16; i++) slvMem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_sck", {31'd0, sck}, 32'd0);
        check("reset_ssel", {31'd0, ssel}, 32'd1);
        check("reset_mosi", {31'd0, mosi}, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rx", {24'd0, rx_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic byte and trailing chip-select timing
        issue(8'hA5, 1'b0, 8'h3C, e0);
        waitCyc(e0 + 67);
        check("trail_ssel_low", {31'd0, ssel}, 32'd0);
        check("trail_ready_low", {31'd0, ready}, 32'd0);
        @(negedge clk);
        check("trail_ssel_high", {31'd0, ssel}, 32'd1);
        check("trail_ready_high", {31'd0, ready}, 32'd1);

        issue(8'hFF, 1'b0, 8'hFF, e0);
        waitIdle();
        issue(8'h00, 1'b0, 8'h00, e0);
        waitIdle();

        // Burst with chip-select held
        issue(8'h11, 1'b1, 8'hA1, e0);
        burstOn = 1'b1;
        issue(8'h22, 1'b1, 8'hB2, e0);
        issue(8'h33, 1'b0, 8'hC4, e0);
        waitCyc(e0 + 67);
        burstOn = 1'b0;
        check("burst_ssel_high_cycles", sselHigh, 32'd0);
        check("burst_ssel_end_low", {31'd0, ssel}, 32'd0);
        @(negedge clk);
        check("burst_ssel_release", {31'd0, ssel}, 32'd1);

        // Start while busy is ignored
        issue(8'hC3, 1'b0, 8'h96, e0);
        waitCyc(e0 + 9);
        tx_data = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ready", {31'd0, ready}, 32'd0);
        waitCyc(e0 + 63);
        check("busy_ready_late", {31'd0, ready}, 32'd0);
        waitIdle();

        // Asynchronous reset mid-byte
        issue(8'h47, 1'b0, 8'hE1, e0);
        waitCyc(e0 + 19);
        #2 reset = 1'b1;
        #1;
        check("areset_sck", {31'd0, sck}, 32'd0);
        check("areset_ssel", {31'd0, ssel}, 32'd1);
        check("areset_mosi", {31'd0, mosi}, 32'd0);
        check("areset_ready", {31'd0, ready}, 32'd1);
        void'(expQ.pop_back());
        void'(slvExpQ.pop_back());
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(8'h81, 1'b0, 8'h7E, e0);
        waitIdle();
        repeat (10) @(negedge clk);

        check("exp_left", expQ.size(), 32'd0);
        check("slave_exp_left", slvExpQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
Name: spi_master

Overview:
- Mode-0 SPI master that drives the sck/mosi/ssel/miso pins of SPI_slave from a byte-wide request interface.
- Sits directly upstream of SPI_slave. Each accepted byte is shifted out MSB-first while the reply byte is captured from miso.
- Provides optional chip-select hold, so multi-byte transactions keep ssel low between bytes.

Parameters:
- CLK_DIV, 4, clk cycles per sck half-period. Legal range is 2..255. Values ≥4 are required against SPI_slave, because its edge detector needs this spacing.
- DATA_W, 8, bits per transfer.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a transfer; accepted only when ready=1
- tx_data  in  DATA_W  byte to send; latched on accept
- hold_ss  in  1  latched on accept; 1 keeps ssel low after this byte
- ready  out  1  master idle and able to accept start
- done  out  1  one-cycle pulse: rx_data is valid
- rx_data  out  DATA_W  last received byte; held until next done
- sck  out  1  SPI clock; idles 0
- mosi  out  1  SPI data out; changes only while sck=0
- miso  in  1  SPI data in
- ssel  out  1  active-low slave select

Behaviour:
- Reset (async, active-high) forces all of the following, with any transfer abandoned mid-byte and no done pulse:
  - state=IDLE
  - sck=0, mosi=0, ssel=1
  - ready=1, done=0
  - rx_data=0, bit counter=0, divider=0
- Registers:
  - All outputs are registered.
  - ready is a registered decode of state==IDLE.
- States: IDLE, LEAD, HIGH, LOW, TRAIL.
- IDLE:
  - sck=0. ssel keeps its last value: 1 after reset or trail, 0 if the previous byte had hold_ss=1.
  - On start&ready at edge E0, the block:
    - latches tx_data into the shift register and latches hold_ss;
    - drives ssel=0 and mosi=tx_data[DATA_W-1];
    - sets ready=0 and goes to LEAD.
- Divider: counts CLK_DIV cycles in every non-IDLE state and advances state on terminal count.
- LEAD → HIGH:
  - At edge E0+CLK_DIV: sck=1.
  - miso is sampled at that same edge and shifted into the LSB of the receive register.
- HIGH → LOW or IDLE/TRAIL:
  - After CLK_DIV cycles: sck=0.
  - If DATA_W bits are complete:
    - rx_data ← receive register and done=1 for one cycle.
    - Then go to IDLE if hold_ss=1 (ready=1 in the same cycle as done).
    - Otherwise go to TRAIL.
  - Else: mosi ← next lower bit and go to LOW.
- LOW → HIGH: after CLK_DIV cycles, sck=1 and miso is sampled.
- Timing:
  - The k-th rising sck edge (k=1..DATA_W) is at E0+(2k-1)·CLK_DIV.
  - The final fall and the done pulse are at E0+2·DATA_W·CLK_DIV.
- TRAIL:
  - ssel stays 0 for CLK_DIV cycles.
  - Then ssel=1, ready=1, IDLE.
  - The byte-to-byte turnaround is therefore (2·DATA_W+1)·CLK_DIV cycles.
- start while ready=0 is ignored. It is not queued, and tx_data changes during a transfer have no effect.
- start in the same cycle as done with hold_ss previously 1:
  - Accepted only if ready=1, i.e. the next cycle at the earliest.
  - ssel stays low continuously.
- Bit order is MSB-first on both mosi and the receive side. rx_data[DATA_W-1] is the first bit received.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined:
  - The miso pin is ignored; the sampled bit is the internal mosi register value.
  - rx_data equals tx_data after every transfer, for self-test without a slave.
  - Pins behave identically otherwise.
- Undefined: the miso pin is sampled as described.

Test Plan:
- Basic transfer, CLK_DIV=4, SPI_slave attached with dataToSend=0x3C; start with tx_data=0xA5, hold_ss=0:
  - slave byteReceived with receivedData=0xA5;
  - master done at E0+64 with rx_data=0x3C;
  - ssel rises at E0+68; ready=1.
- All-ones then all-zeros: tx 0xFF with slave sending 0xFF, then tx 0x00 with slave sending 0x00 → rx_data=0xFF then 0x00, and the slave reports matching bytes.
- Burst: three starts (0x11, 0x22 hold_ss=1; 0x33 hold_ss=0) → ssel low continuously from the first accept until 4 cycles after the third done; slave receives 0x11, 0x22, 0x33 in order.
- Busy rejection: pulse start with tx_data=0x5A at E0+10 during a 0xC3 transfer → mosi pattern stays 0xC3; exactly one done; ready stays 0 until the end.
- Reset mid-byte: assert reset at E0+20 → sck=0, ssel=1, mosi=0, ready=1 immediately (asynchronous); no done; the next start of 0x81 transfers correctly.
- Loopback: compile with SPI_MASTER_LOOPBACK_EN, miso tied to 0, tx 0x6E → rx_data=0x6E.
